// File: rtl/c1541_gcr_track_loader.sv
// SD-side loader for one drive's 8 KB GCR track buffer: settles on the requested
// half-track, writes back a dirty track, then reads the new 16-block slot.
module c1541_gcr_track_loader #(
  parameter int unsigned BLK_PER_TRK = 16,
  parameter int unsigned MAX_HTRK    = 84,
  parameter int unsigned SETTLE      = 2048
) (
  input  logic        sd_clk,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [6:0]  htrack,
  input  logic        wr_toggle,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic        sd_buff_wr,
  output logic [13:0] buf_addr,
  output logic        buf_wr,
  output logic        busy,
  output logic        dirty
);

  localparam int unsigned SLOT_W = 7;
  localparam int unsigned BLK_W  = (BLK_PER_TRK > 1) ? $clog2(BLK_PER_TRK) : 1;
  localparam int unsigned CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WB_REQ, S_WB_WAIT, S_RD_REQ, S_RD_WAIT
  } state_t;

  state_t              state;
  logic [SLOT_W-1:0]   ht_s1, ht_s2, req_slot, last_slot, cur_slot, tgt_slot;
  logic [2:0]          wt_s;
  logic [CNT_W-1:0]    cnt;
  logic [BLK_W-1:0]    blk;
  logic                ack_q, loaded, need_load, abort;
  logic                reading, blk_done, last_blk, stop;

  assign req_slot = (ht_s2 > SLOT_W'(MAX_HTRK - 1)) ? SLOT_W'(MAX_HTRK - 1) : ht_s2;
  assign reading  = (state == S_RD_REQ) || (state == S_RD_WAIT);
  assign blk_done = ack_q & ~sd_ack;
  assign last_blk = (blk == BLK_W'(BLK_PER_TRK - 1));
  // A mount or a pending mount ends the transfer at the current block boundary.
  assign stop     = abort | img_mounted;

  assign buf_addr = 14'({blk, sd_buff_addr});
  assign buf_wr   = sd_buff_wr & sd_ack & reading;

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ht_s1     <= '0;
      ht_s2     <= '0;
      last_slot <= '0;
      cur_slot  <= '0;
      tgt_slot  <= '0;
      wt_s      <= '0;
      cnt       <= '0;
      blk       <= '0;
      ack_q     <= 1'b0;
      loaded    <= 1'b0;
      need_load <= 1'b0;
      abort     <= 1'b0;
      sd_lba    <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      busy      <= 1'b1;
      dirty     <= 1'b0;
    end else begin
      ht_s1     <= htrack;
      ht_s2     <= ht_s1;
      last_slot <= req_slot;
      wt_s      <= {wt_s[1:0], wr_toggle};
      ack_q     <= sd_ack;
      sd_lba    <= 32'(cur_slot) * 32'(BLK_PER_TRK) + 32'(blk);
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;

      if ((wt_s[2] ^ wt_s[1]) && !busy) dirty <= 1'b1;

      case (state)
        S_IDLE: begin
          if ((req_slot != cur_slot) || need_load) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end
        end
        S_SETTLE: begin
          if (img_mounted || (req_slot != last_slot)) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(SETTLE - 1)) begin
            cnt   <= '0;
            abort <= 1'b0;
            blk   <= '0;
            // Settled back onto the track already held: nothing to move.
            if (loaded && !need_load && (req_slot == cur_slot)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (dirty && !img_readonly && loaded) begin
              tgt_slot <= req_slot;
              state    <= S_WB_REQ;
              busy     <= 1'b1;
            end else begin
              cur_slot <= req_slot;
              dirty    <= 1'b0;
              loaded   <= 1'b0;
              state    <= S_RD_REQ;
              busy     <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WB_REQ: begin
          if (sd_ack) state <= S_WB_WAIT;
          else        sd_wr <= 1'b1;
        end
        S_WB_WAIT: begin
          if (blk_done) begin
            if (stop) begin
              state <= S_SETTLE;
              cnt   <= '0;
              busy  <= ~loaded;
            end else if (last_blk) begin
              dirty <= 1'b0;
              blk   <= '0;
              if (req_slot == tgt_slot) begin
                cur_slot <= tgt_slot;
                loaded   <= 1'b0;
                state    <= S_RD_REQ;
              end else begin
                // Old track is clean and still valid while the new target settles.
                state <= S_SETTLE;
                cnt   <= '0;
                busy  <= 1'b0;
              end
            end else begin
              blk   <= blk + BLK_W'(1);
              state <= S_WB_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (sd_ack) state <= S_RD_WAIT;
          else        sd_rd <= 1'b1;
        end
        S_RD_WAIT: begin
          if (blk_done) begin
            if (stop || (req_slot != cur_slot)) begin
              state  <= S_SETTLE;
              cnt    <= '0;
              loaded <= 1'b0;
            end else if (last_blk) begin
              loaded    <= 1'b1;
              need_load <= 1'b0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end else begin
              blk   <= blk + BLK_W'(1);
              state <= S_RD_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // New image: old buffer contents are meaningless and must never be written back.
      if (img_mounted) begin
        need_load <= 1'b1;
        loaded    <= 1'b0;
        dirty     <= 1'b0;
        busy      <= 1'b1;
        if (state != S_IDLE && state != S_SETTLE) abort <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c1541_gcr_track_loader.sv
// Directed bench for c1541_gcr_track_loader with a simple SD controller model.
module tb_c1541_gcr_track_loader;

  localparam int SETTLE = 2048;

  logic        sd_clk = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic        img_readonly;
  logic [6:0]  htrack;
  logic        wr_toggle;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic        sd_buff_wr;
  logic [13:0] buf_addr;
  logic        buf_wr;
  logic        busy;
  logic        dirty;

  c1541_gcr_track_loader #(.BLK_PER_TRK(16), .MAX_HTRK(84), .SETTLE(SETTLE)) dut (
    .sd_clk(sd_clk), .reset(reset), .img_mounted(img_mounted), .img_readonly(img_readonly),
    .htrack(htrack), .wr_toggle(wr_toggle), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_wr(sd_buff_wr),
    .buf_addr(buf_addr), .buf_wr(buf_wr), .busy(busy), .dirty(dirty)
  );

  always #5 sd_clk = ~sd_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // SD controller model: logs every request, acks after 2 cycles, streams nbytes.
  typedef struct {
    logic        wr;
    logic [31:0] lba;
  } xfer_t;

  xfer_t       log_q[$];
  int          nbytes  = 8;
  logic        in_xfer = 1'b0;
  logic [31:0] cur_lba = '0;
  bit          cov[16384];
  bit          cov_on  = 1'b0;

  initial begin : sd_model
    xfer_t x;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0;
    forever begin
      @(negedge sd_clk);
      if (!reset && (sd_rd || sd_wr)) begin
        x.wr = sd_wr; x.lba = sd_lba;
        log_q.push_back(x);
        cur_lba = sd_lba; in_xfer = 1'b1;
        repeat (2) @(negedge sd_clk);
        sd_ack = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
          sd_buff_addr = 9'(i); sd_buff_wr = 1'b1;
          #1;
          if (x.wr) chk("buf_wr_during_write", 32'(buf_wr), 32'd0);
          else begin
            chk("buf_wr_during_read", 32'(buf_wr), 32'd1);
            chk("buf_addr", 32'(buf_addr), 32'({x.lba[3:0], 9'(i)}));
            if (cov_on) cov[buf_addr] = 1'b1;
          end
          @(negedge sd_clk);
        end
        sd_buff_wr = 1'b0; sd_ack = 1'b0; in_xfer = 1'b0;
      end
    end
  end

  task automatic wait_busy(input logic val, input int limit, input string tag);
    int t = 0;
    while (busy !== val && t < limit) begin @(negedge sd_clk); t++; end
    chk({tag, " busy_wait"}, 32'(busy), 32'(val));
  endtask

  task automatic check_log(input string tag, input int nwr, input int wbase, input int nrd, input int rbase);
    chk({tag, " xfer_count"}, 32'(log_q.size()), 32'(nwr + nrd));
    for (int i = 0; i < log_q.size() && i < nwr + nrd; i++) begin
      logic exp_wr;
      int   exp_lba;
      exp_wr  = (i < nwr);
      exp_lba = exp_wr ? wbase + i : rbase + i - nwr;
      chk($sformatf("%s xfer%0d_dir", tag, i), 32'(log_q[i].wr), 32'(exp_wr));
      chk($sformatf("%s xfer%0d_lba", tag, i), log_q[i].lba, 32'(exp_lba));
    end
  endtask

  typedef struct {
    logic [6:0] ht;
    logic       ro;
    logic       tog;
    logic       mnt;
    int         nb;
    logic       lat;
    int         nwr;
    int         wbase;
    int         nrd;
    int         rbase;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    int lat;
    int busy_hi;
    int cov_cnt;
    // {htrack, readonly, toggle, mount, bytes/blk, check latency, #wr, wr LBA, #rd, rd LBA}
    vecs[0] = '{7'd36, 1'b0, 1'b0, 1'b1, 512, 1'b1,  0,   0, 16,  576};
    vecs[1] = '{7'd38, 1'b0, 1'b1, 1'b0,   8, 1'b0, 16, 576, 16,  608};
    vecs[2] = '{7'd36, 1'b0, 1'b0, 1'b0,   8, 1'b0,  0,   0, 16,  576};
    vecs[3] = '{7'd38, 1'b1, 1'b1, 1'b0,   8, 1'b0,  0,   0, 16,  608};
    vecs[4] = '{7'd90, 1'b0, 1'b0, 1'b0,   8, 1'b0,  0,   0, 16, 1328};
    vecs[5] = '{7'd90, 1'b0, 1'b1, 1'b1,   8, 1'b0,  0,   0, 16, 1328};

    reset = 1'b1; img_mounted = 1'b0; img_readonly = 1'b0; htrack = '0; wr_toggle = 1'b0;
    repeat (3) @(negedge sd_clk);
    chk("reset sd_rd", 32'(sd_rd), 0);
    chk("reset sd_wr", 32'(sd_wr), 0);
    chk("reset sd_lba", sd_lba, 0);
    chk("reset busy", 32'(busy), 1);
    chk("reset dirty", 32'(dirty), 0);
    chk("reset buf_wr", 32'(buf_wr), 0);
    reset = 1'b0;
    repeat (5) @(negedge sd_clk);
    chk("idle unloaded busy", 32'(busy), 1);
    chk("idle unloaded no traffic", 32'(log_q.size()), 0);

    for (int v = 0; v < 6; v++) begin
      img_readonly = vecs[v].ro;
      nbytes = vecs[v].nb;
      cov_on = (v == 0);
      if (vecs[v].tog) begin
        wr_toggle = ~wr_toggle;
        repeat (6) @(negedge sd_clk);
        chk($sformatf("v%0d dirty_set", v), 32'(dirty), 1);
        chk($sformatf("v%0d busy_idle", v), 32'(busy), 0);
      end
      log_q.delete();
      htrack = vecs[v].ht;
      lat = 0;
      if (vecs[v].mnt) begin
        img_mounted = 1'b1;
        @(negedge sd_clk);
        img_mounted = 1'b0;
        lat = 1;
      end
      if (vecs[v].lat) begin
        while (!sd_rd && lat < 3000) begin @(negedge sd_clk); lat++; end
        n_checks++;
        if (lat < SETTLE || lat > SETTLE + 10) begin
          n_fail++;
          $display("FAIL v%0d load_latency: got %0d cycles, expected %0d..%0d", v, lat, SETTLE, SETTLE + 10);
        end
      end
      wait_busy(1'b1, 4000, $sformatf("v%0d rise", v));
      wait_busy(1'b0, 30000, $sformatf("v%0d fall", v));
      repeat (4) @(negedge sd_clk);
      check_log($sformatf("v%0d", v), vecs[v].nwr, vecs[v].wbase, vecs[v].nrd, vecs[v].rbase);
      chk($sformatf("v%0d dirty_end", v), 32'(dirty), 0);
      chk($sformatf("v%0d sd_rd_end", v), 32'(sd_rd), 0);
      chk($sformatf("v%0d sd_wr_end", v), 32'(sd_wr), 0);
      if (v == 0) begin
        cov_cnt = 0;
        for (int a = 0; a < 16384; a++) if (cov[a]) cov_cnt += (a < 8192) ? 1 : 100000;
        chk("v0 buf_addr_coverage", 32'(cov_cnt), 32'd8192);
      end
    end
    img_readonly = 1'b0;

    // Slot change during read block 5: block completes, then a fresh load of slot 40.
    log_q.delete();
    htrack = 7'd36;
    lat = 0;
    while (!(in_xfer && cur_lba == 32'd581) && lat < 6000) begin @(negedge sd_clk); lat++; end
    chk("abort reached_block5", 32'(in_xfer && cur_lba == 32'd581), 1);
    htrack = 7'd40;
    wait_busy(1'b0, 30000, "abort");
    repeat (4) @(negedge sd_clk);
    chk("abort xfer_count", 32'(log_q.size()), 22);
    for (int i = 0; i < log_q.size() && i < 22; i++) begin
      chk($sformatf("abort xfer%0d_dir", i), 32'(log_q[i].wr), 0);
      chk($sformatf("abort xfer%0d_lba", i), log_q[i].lba, (i < 6) ? 32'(576 + i) : 32'(640 + i - 6));
    end

    // Brief excursion to a neighbouring track and back: no traffic, buffer stays valid.
    log_q.delete();
    busy_hi = 0;
    htrack = 7'd41;
    repeat (300) begin @(negedge sd_clk); if (busy) busy_hi++; end
    htrack = 7'd40;
    repeat (2500) begin @(negedge sd_clk); if (busy) busy_hi++; end
    chk("bounce busy_cycles", 32'(busy_hi), 0);
    chk("bounce xfer_count", 32'(log_q.size()), 0);

    // Reset while a read request is pending drops it on the next edge.
    htrack = 7'd44;
    lat = 0;
    while (!sd_rd && lat < 3000) begin @(negedge sd_clk); lat++; end
    chk("midreset sd_rd_seen", 32'(sd_rd), 1);
    reset = 1'b1;
    @(negedge sd_clk);
    chk("midreset sd_rd", 32'(sd_rd), 0);
    chk("midreset sd_wr", 32'(sd_wr), 0);
    chk("midreset sd_lba", sd_lba, 0);
    chk("midreset busy", 32'(busy), 1);
    chk("midreset dirty", 32'(dirty), 0);
    reset = 1'b0;
    repeat (20) @(negedge sd_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c1541_gcr_track_loader.md
# c1541_gcr_track_loader

Per-drive SD-side track loader that fills and flushes the 8 KB GCR track buffer consumed by the direct-GCR head stage. It watches the requested half-track, waits for the head to settle, and writes the current track back if it is dirty. It then reads the new track's fixed 16-block slot from the mounted image and drives `busy` to the head stage for the whole transfer. It sits between the MiSTer SD block interface and the track buffer's SD-side port.

## Interface
Parameters:
- `BLK_PER_TRK`, default 16: 512-byte SD blocks per half-track slot. Slot size is 8192 bytes; bytes 0/1 hold the track length.
- `MAX_HTRK`, default 84: number of half-track slots in the image.
- `SETTLE`, default 2048: `sd_clk` cycles the requested half-track must stay stable before a load starts.

Ports:
- `sd_clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high; clock sd_clk.
- `img_mounted`, in, 1: one-cycle pulse when a new image is mounted.
- `img_readonly`, in, 1: level; when high, writeback is suppressed.
- `htrack`, in, 7: requested half-track. Asynchronous; synchronised internally with 2 FFs.
- `wr_toggle`, in, 1: toggles once per head-stage buffer write. Asynchronous; 2-FF synchronised; an edge marks the track dirty.
- `sd_lba`, out, 32: block address, `cur_slot*BLK_PER_TRK + blk`.
- `sd_rd`, out, 1: block read request.
- `sd_wr`, out, 1: block write request.
- `sd_ack`, in, 1: SD controller acknowledge; high while a block transfers.
- `sd_buff_addr`, in, 9: byte index within the block.
- `sd_buff_wr`, in, 1: byte strobe from the SD controller.
- `buf_addr`, out, 14: `{1'b0, blk[3:0], sd_buff_addr}` to the track buffer.
- `buf_wr`, out, 1: `sd_buff_wr & sd_ack & reading`.
- `busy`, out, 1: buffer contents are invalid or being transferred.
- `dirty`, out, 1: current track modified since load.

## Operation
- Requested slot: `min(htrack_sync, MAX_HTRK-1)`.
- FSM states: IDLE, SETTLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT.
- **IDLE**
  - Go to SETTLE and clear the settle counter if the requested slot differs from `cur_slot`, or `need_load`=1.
- **SETTLE**
  - Any change of the requested slot clears the counter.
  - When the counter reaches `SETTLE-1`:
    - if `dirty & ~img_readonly & loaded`, go to WB_REQ with `blk`=0;
    - otherwise latch `cur_slot`, clear `dirty`, set `blk`=0 and go to RD_REQ.
- **WB_REQ / RD_REQ**
  - Drive `sd_lba`, assert `sd_wr` / `sd_rd`, hold until `sd_ack`=1.
  - On `sd_ack`=1, drop the request and go to WB_WAIT / RD_WAIT.
- **WB_WAIT / RD_WAIT**
  - On the `sd_ack` falling edge the block is done.
  - If `blk` = `BLK_PER_TRK-1`:
    - after writeback, clear `dirty`, latch the new `cur_slot`, go to RD_REQ with `blk`=0;
    - after a read, set `loaded`, clear `need_load`, go to IDLE.
  - Otherwise increment `blk` and go back to the REQ state.
- `busy` = (state != IDLE) | ~loaded.
- `dirty` is set on a synchronised `wr_toggle` edge only while `busy`=0; edges while `busy`=1 are ignored.
- Slot change during a read: the in-flight block completes; at that block boundary go to SETTLE (the partial load is discarded; `loaded` is cleared).
- Slot change during writeback: the writeback runs to completion, then SETTLE re-evaluates.
- `img_mounted` at any time:
  - set `need_load`, clear `loaded` and `dirty`;
  - if a request or ack is in flight, finish that block first, then go to SETTLE;
  - never write back to the new image.
- Read-only image: `dirty` may be set but writeback is never entered.

## Timing
- Reset values:
  - outputs: `sd_rd`=0, `sd_wr`=0, `sd_lba`=0, `busy`=1, `dirty`=0, `buf_wr`=0;
  - internal: state IDLE, `cur_slot`=0, `loaded`=0, `need_load`=0.
- Reset mid-transfer drops all requests on the next edge.
- `sd_rd`/`sd_wr` assert on the first cycle after entering the REQ state and deassert on the cycle after `sd_ack` is sampled high.
- `buf_addr` and `buf_wr` are combinational from `sd_buff_addr` and `sd_buff_wr`; zero added latency.
- Synchroniser latency is 2 cycles.
- Load latency is `SETTLE` + 2 + 16 × (SD handshake) cycles.
- `busy` deasserts on the cycle after the last `sd_ack` fall.

## Test plan
- Reset, mount image, `htrack`=36 → after 2048+2 cycles, 16 reads with LBAs 576..591; `buf_addr` covers 0..8191; `busy` falls after the 16th ack.
- With track 36 loaded, toggle `wr_toggle`, set `htrack`=38 → 16 writes at LBAs 576..591, then 16 reads at LBAs 608..623; `dirty`=0 at the end.
- Same as above with `img_readonly`=1 → no `sd_wr`; reads at LBAs 608..623 only.
- `htrack` 36→37→36 within 1000 cycles → settle restarts; no SD traffic; `busy` stays 0.
- `htrack`=90 → clamped to slot 83; reads at LBAs 1328..1343.
- Change `htrack` to 40 during read block 5 → block 5 completes, settle runs, reads restart at LBA 640.
- `img_mounted` pulse while dirty → no writeback; full reload of the current slot.
